// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Round-robin arbiter guarding a single shared WIDTH-bit register. Four
//   requesters each present an op (load/set/clear/nop) and load data; one is
//   serviced per clock. A serviced requester that also asserts lock keeps
//   exclusive ownership for up to LOCK_MAX consecutive edges. After that the
//   lock is forced open and timeout pulses.
//
// Ports
//   clk      clock, all state updates on the rising edge
//   reset    synchronous, active-high
//   req      [3:0]        per-requester access request
//   lock     [3:0]        per-requester hold-ownership request (qualified by req)
//   op       [7:0]        op[2i+1:2i] for requester i: 00 load, 01 set, 10 clear, 11 nop
//   wdata    [4*WIDTH-1:0] load data, slice i belongs to requester i
//   q        [WIDTH-1:0]  shared register contents
//   ack      [3:0]        registered one-hot, one-cycle pulse per serviced request
//   locked   high while ownership is held
//   owner    [1:0]        index of the current or most recent lock holder
//   timeout  one-cycle pulse when a lock is forcibly released
module reg_access_arbiter #(
  parameter int WIDTH    = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [3:0]           lock,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]     q,
  output logic [3:0]           ack,
  output logic                 locked,
  output logic [1:0]           owner,
  output logic                 timeout
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  // Round-robin search from ptr upward, wrapping 3->0.
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Whoever is serviced this edge: the round-robin winner when idle, or the
  // owner (only if it requests) when locked.
  logic       svc_en;
  logic [1:0] svc_idx;

  always_comb begin
    if (state == IDLE) begin
      svc_en  = found;
      svc_idx = win;
    end else begin
      svc_en  = req[owner];
      svc_idx = owner;
    end
  end

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] code,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] d);
    case (code)
      2'b00:   apply_op = d;
      2'b01:   apply_op = '1;
      2'b10:   apply_op = '0;
      default: apply_op = cur;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      q       <= '0;
      ack     <= '0;
      owner   <= '0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      ack     <= '0;
      timeout <= 1'b0;
      if (svc_en) begin
        q            <= apply_op(op[2*svc_idx +: 2], q, wdata[WIDTH*svc_idx +: WIDTH]);
        ack[svc_idx] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            // ptr moves past the winner now, so after any later release the
            // other pending requesters are searched before the old owner.
            ptr <= win + 2'd1;
            if (lock[win]) begin
              state <= LOCKED;
              owner <= win;
              cnt   <= CW'(1);
            end
          end
        end
        LOCKED: begin
          if (!lock[owner]) begin
            state <= IDLE;
          end else if (cnt == CW'(LOCK_MAX - 1)) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 4, shared register width
- LOCK_MAX, 8, maximum consecutive ownership cycles per lock (≥2)
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  4  per-requester access request, bit i = requester i
- lock  in  4  per-requester hold-ownership request, meaningful only with req
- op  in  8  2-bit op per requester, op[2i+1:2i]: 00 load, 01 set, 10 clear, 11 nop
- wdata  in  4*WIDTH  load data, wdata[WIDTH*i +: WIDTH] = requester i
- q  out  WIDTH  shared register contents
- ack  out  4  one-hot, registered, one-cycle pulse per serviced request
- locked  out  1  high while in LOCKED state
- owner  out  2  index of current or last lock holder
- timeout  out  1  one-cycle pulse on forced lock release
REQ-003 Reset SHALL be reset, synchronous, active-high; clock SHALL be clk.

Function
REQ-004 State machine SHALL have exactly two states, IDLE and LOCKED.
REQ-005 In IDLE, winner SHALL be the first asserted req bit searched round-robin from ptr upward, wrapping 3->0.
REQ-006 At most one requester SHALL be serviced per cycle; ack SHALL never have more than one bit set.
REQ-007 Servicing requester w SHALL at the same edge: update q per op[w], set ack[w]=1, clear all other ack bits.
REQ-008 Op effect: load q<=wdata slice w; set q<=all ones; clear q<=0; nop q unchanged but still acked.
REQ-009 Latency: request sampled at edge N SHALL see q updated and ack high after edge N, i.e. during cycle N+1.
REQ-010 On any IDLE service, ptr SHALL become (w+1) mod 4.
REQ-011 No req asserted in IDLE: q, ptr unchanged, ack=0.
REQ-012 IDLE service with lock[w]=1 SHALL enter LOCKED, set owner=w, cnt=1.
REQ-013 In LOCKED, only owner SHALL be serviced; other req bits SHALL be ignored and stay pending (no ack).
REQ-014 In LOCKED, owner with req low SHALL get no ack, and q SHALL hold.
REQ-015 In LOCKED, lock[owner]=0 at an edge SHALL return to IDLE; that edge's owner op SHALL still apply if req[owner]=1.
REQ-016 In LOCKED, lock[owner]=1 and cnt==LOCK_MAX-1 SHALL force IDLE with timeout=1 for one cycle; that edge's owner op SHALL still apply.
REQ-017 Otherwise in LOCKED, cnt SHALL increment; total ownership SHALL never exceed LOCK_MAX edges, including the entry edge.
REQ-018 After any release, ptr SHALL already point past owner, so other pending requesters win before owner.
REQ-019 A requester with lock high but req low SHALL be ignored.
REQ-020 locked output SHALL equal (state==LOCKED); owner SHALL hold its value after release.

Reset
REQ-021 reset=1 SHALL take priority over all activity, including mid-lock: q=0, ack=0, locked=0, owner=0, timeout=0, ptr=0, cnt=0, state IDLE.
REQ-022 First cycle after reset deassertion SHALL arbitrate normally from ptr=0.

Verification
REQ-023 Bench SHALL cover:
- req=1111, all op=load, wdata slices 1,2,3,4, held 4 cycles -> ack 0001,0010,0100,1000; q 1,2,3,4
- req[2] op=set, then req[2] op=clear -> q=F then 0, ack[2] each cycle
- req[1] lock[1] 3 cycles while req[3] high -> ack[1] x3, locked high, ack[3] one cycle after release
- lock[0] held 12 cycles, LOCK_MAX=8 -> 8 ack[0] pulses, timeout pulse after 8th, ack[3] next cycle if req[3] pending
- reset asserted during LOCKED, q=A -> next cycle q=0, locked=0, ack=0
- req=0000 for 5 cycles -> q stable, ack=0, ptr unchanged
